bsg_operand_pair_join: RTL and testbench

Upstream operand-alignment stage for the 16-bit bitwise two-input gate datapath. It accepts operand A and operand B on two independent valid/ready channels and buffers each in a 2-entry FIFO. It presents a matched {A, B} pair on a valid/yumi output only when both sides hold data, so the combinational gate downstream always sees operands that belong together. Pairs are consumed in order, one per cycle at full throughput.

---
 rtl/bsg_operand_pair_join.sv | 129 ++++++++++++
 tb/tb_bsg_operand_pair_join.sv | 234 +++++++++++++++++++++++
 2 files changed

// File: rtl/bsg_operand_pair_join.sv
// Buffers operands A and B in independent 2-entry FIFOs and presents a
// matched {A, B} pair on a valid/yumi port once both sides hold data.

module bsg_operand_pair_join_fifo #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               v_i,
  input  logic [width_p-1:0] data_i,
  output logic               ready_o,
  input  logic               deq_i,
  output logic               nonempty_o,
  output logic [width_p-1:0] data_o
);

  localparam int els_p = 2;

  typedef enum logic [1:0] {
    EMPTY = 2'd0,
    ONE   = 2'd1,
    FULL  = 2'd2
  } count_e;

  logic [width_p-1:0] r_mem [els_p];
  logic               r_wptr;
  logic               r_rptr;
  count_e             r_count;
  count_e             w_countNext;
  logic               w_enq;

  // Ready comes only from registered occupancy, forced low while in reset.
  assign ready_o    = (r_count != FULL) & ~reset_i;
  assign w_enq      = v_i & ready_o;
  assign nonempty_o = (r_count != EMPTY);
  assign data_o     = r_mem[r_rptr];

  always_comb begin
    w_countNext = r_count;
    if (w_enq && !deq_i) begin
      unique case (r_count)
        EMPTY:   w_countNext = ONE;
        ONE:     w_countNext = FULL;
        default: w_countNext = r_count;
      endcase
    end else if (deq_i && !w_enq) begin
      unique case (r_count)
        FULL:    w_countNext = ONE;
        ONE:     w_countNext = EMPTY;
        default: w_countNext = r_count;
      endcase
    end
  end

  always_ff @(posedge clk_i) begin
    if (reset_i) begin
      r_mem[0] <= '0;
      r_mem[1] <= '0;
      r_wptr   <= 1'b0;
      r_rptr   <= 1'b0;
      r_count  <= EMPTY;
    end else begin
      if (w_enq) begin
        r_mem[r_wptr] <= data_i;
        r_wptr        <= ~r_wptr;
      end
      if (deq_i) begin
        r_rptr <= ~r_rptr;
      end
      r_count <= w_countNext;
    end
  end

endmodule

module bsg_operand_pair_join #(
  parameter int width_p = 16
) (
  input  logic               clk_i,
  input  logic               reset_i,
  input  logic               a_v_i,
  input  logic [width_p-1:0] a_data_i,
  output logic               a_ready_o,
  input  logic               b_v_i,
  input  logic [width_p-1:0] b_data_i,
  output logic               b_ready_o,
  output logic               v_o,
  output logic [width_p-1:0] a_o,
  output logic [width_p-1:0] b_o,
  input  logic               yumi_i
);

  logic w_aNonempty;
  logic w_bNonempty;
  logic w_deq;

  // Qualifying yumi with v_o keeps an illegal consume from touching state.
  assign v_o   = w_aNonempty & w_bNonempty;
  assign w_deq = yumi_i & v_o;

  bsg_operand_pair_join_fifo #(.width_p(width_p)) u_aFifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (a_v_i),
    .data_i     (a_data_i),
    .ready_o    (a_ready_o),
    .deq_i      (w_deq),
    .nonempty_o (w_aNonempty),
    .data_o     (a_o)
  );

  bsg_operand_pair_join_fifo #(.width_p(width_p)) u_bFifo (
    .clk_i      (clk_i),
    .reset_i    (reset_i),
    .v_i        (b_v_i),
    .data_i     (b_data_i),
    .ready_o    (b_ready_o),
    .deq_i      (w_deq),
    .nonempty_o (w_bNonempty),
    .data_o     (b_o)
  );

  always_ff @(posedge clk_i) begin
    if (!reset_i) begin
      assert (!(yumi_i && !v_o));
    end
  end

endmodule

// File: tb/tb_bsg_operand_pair_join.sv
// Self-checking bench for bsg_operand_pair_join: queue-based reference model
// compared every cycle, plus directed scenarios with literal expectations.

module tb_bsg_operand_pair_join;

  logic        clk_i;
  logic        reset_i;
  logic        a_v_i;
  logic [15:0] a_data_i;
  logic        a_ready_o;
  logic        b_v_i;
  logic [15:0] b_data_i;
  logic        b_ready_o;
  logic        v_o;
  logic [15:0] a_o;
  logic [15:0] b_o;
  logic        yumi_i;

  int checks = 0;
  int errors = 0;

  logic [15:0] qa[$];
  logic [15:0] qb[$];

  bsg_operand_pair_join #(.width_p(16)) dut (
    .clk_i     (clk_i),
    .reset_i   (reset_i),
    .a_v_i     (a_v_i),
    .a_data_i  (a_data_i),
    .a_ready_o (a_ready_o),
    .b_v_i     (b_v_i),
    .b_data_i  (b_data_i),
    .b_ready_o (b_ready_o),
    .v_o       (v_o),
    .a_o       (a_o),
    .b_o       (b_o),
    .yumi_i    (yumi_i)
  );

  initial begin
    clk_i = 1'b0;
    forever #5 clk_i = ~clk_i;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual,
                             input logic [31:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s: got %0h expected %0h at %0t", name, actual, expected, $time);
    end
  endtask

  // Reference model: two FIFOs of depth 2 updated from pre-edge occupancy.
  always @(posedge clk_i) begin
    bit acceptA, acceptB, pop;
    acceptA = a_v_i && !reset_i && (qa.size() < 2);
    acceptB = b_v_i && !reset_i && (qb.size() < 2);
    pop     = yumi_i && (qa.size() > 0) && (qb.size() > 0);
    if (reset_i) begin
      qa.delete();
      qb.delete();
    end else begin
      if (pop) begin
        void'(qa.pop_front());
        void'(qb.pop_front());
      end
      if (acceptA) qa.push_back(a_data_i);
      if (acceptB) qb.push_back(b_data_i);
    end
  end

  // Compare DUT against the model on every falling edge.
  always @(negedge clk_i) begin
    bit expV;
    expV = (qa.size() > 0) && (qb.size() > 0);
    checkOutput("model_a_ready", {31'd0, a_ready_o}, {31'd0, !reset_i && qa.size() < 2});
    checkOutput("model_b_ready", {31'd0, b_ready_o}, {31'd0, !reset_i && qb.size() < 2});
    checkOutput("model_v", {31'd0, v_o}, {31'd0, expV});
    if (expV) begin
      checkOutput("model_a_head", {16'd0, a_o}, {16'd0, qa[0]});
      checkOutput("model_b_head", {16'd0, b_o}, {16'd0, qb[0]});
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic applyStimulus(input logic av, input logic [15:0] ad,
                               input logic bv, input logic [15:0] bd,
                               input logic y);
    a_v_i    = av;
    a_data_i = ad;
    b_v_i    = bv;
    b_data_i = bd;
    yumi_i   = y;
  endtask

  initial begin
    int pops;
    reset_i = 1'b1;
    applyStimulus(0, 16'h0, 0, 16'h0, 0);

    // Reset held for three cycles
    for (int i = 0; i < 3; i++) begin
      tick();
      checkOutput("rst_v", {31'd0, v_o}, 32'd0);
      checkOutput("rst_a_ready", {31'd0, a_ready_o}, 32'd0);
      checkOutput("rst_b_ready", {31'd0, b_ready_o}, 32'd0);
      checkOutput("rst_a_o", {16'd0, a_o}, 32'd0);
      checkOutput("rst_b_o", {16'd0, b_o}, 32'd0);
    end
    reset_i = 1'b0;
    #1;
    checkOutput("post_rst_a_ready", {31'd0, a_ready_o}, 32'd1);
    checkOutput("post_rst_b_ready", {31'd0, b_ready_o}, 32'd1);
    checkOutput("post_rst_v", {31'd0, v_o}, 32'd0);

    // Single pair, A at edge 1, B at edge 3
    applyStimulus(1, 16'h00F0, 0, 16'h0, 0);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("single_v_e1", {31'd0, v_o}, 32'd0);
    tick();
    checkOutput("single_v_e2", {31'd0, v_o}, 32'd0);
    applyStimulus(0, 16'h0, 1, 16'h0F0F, 0);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 1);
    checkOutput("single_v_e3", {31'd0, v_o}, 32'd1);
    checkOutput("single_a_o", {16'd0, a_o}, 32'h00F0);
    checkOutput("single_b_o", {16'd0, b_o}, 32'h0F0F);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("single_v_after_pop", {31'd0, v_o}, 32'd0);

    // Skew and backpressure on A
    applyStimulus(1, 16'd1, 0, 16'h0, 0);
    tick();
    applyStimulus(1, 16'd2, 0, 16'h0, 0);
    tick();
    applyStimulus(1, 16'd3, 0, 16'h0, 0);
    checkOutput("skew_a_ready_full", {31'd0, a_ready_o}, 32'd0);
    checkOutput("skew_v_b_empty", {31'd0, v_o}, 32'd0);
    tick();
    checkOutput("skew_a_still_full", {31'd0, a_ready_o}, 32'd0);
    applyStimulus(1, 16'd3, 1, 16'h000A, 0);
    tick();
    checkOutput("skew_pair1_v", {31'd0, v_o}, 32'd1);
    checkOutput("skew_pair1_a", {16'd0, a_o}, 32'd1);
    checkOutput("skew_pair1_b", {16'd0, b_o}, 32'h000A);
    applyStimulus(1, 16'd3, 1, 16'h000B, 1);
    tick();
    checkOutput("skew_a_ready_after_pop", {31'd0, a_ready_o}, 32'd1);
    checkOutput("skew_pair2_a", {16'd0, a_o}, 32'd2);
    checkOutput("skew_pair2_b", {16'd0, b_o}, 32'h000B);
    applyStimulus(1, 16'd3, 0, 16'h0, 1);
    tick();
    applyStimulus(0, 16'h0, 1, 16'h000C, 0);
    checkOutput("skew_v_b_drained", {31'd0, v_o}, 32'd0);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 1);
    checkOutput("skew_a3_head", {16'd0, a_o}, 32'd3);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("skew_drained_v", {31'd0, v_o}, 32'd0);

    // Full-rate stream k / ~k
    pops = 0;
    for (int k = 0; k < 21; k++) begin
      if (k < 20) applyStimulus(1, 16'(k), 1, ~16'(k), 0);
      else        applyStimulus(0, 16'h0, 0, 16'h0, 0);
      yumi_i = v_o;
      if (k >= 1) begin
        checkOutput("stream_v", {31'd0, v_o}, 32'd1);
        checkOutput("stream_a", {16'd0, a_o}, 32'(pops));
        checkOutput("stream_b", {16'd0, b_o}, {16'd0, ~16'(pops)});
      end
      checkOutput("stream_a_ready", {31'd0, a_ready_o}, 32'd1);
      checkOutput("stream_b_ready", {31'd0, b_ready_o}, 32'd1);
      if (v_o) pops++;
      tick();
    end
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("stream_pop_count", 32'(pops), 32'd20);
    checkOutput("stream_v_end", {31'd0, v_o}, 32'd0);

    // Both sides full, push on A with simultaneous pop
    applyStimulus(1, 16'h0011, 1, 16'h0022, 0);
    tick();
    applyStimulus(1, 16'h0033, 1, 16'h0044, 0);
    tick();
    applyStimulus(1, 16'h0055, 0, 16'h0, 1);
    checkOutput("full_a_ready", {31'd0, a_ready_o}, 32'd0);
    checkOutput("full_b_ready", {31'd0, b_ready_o}, 32'd0);
    checkOutput("full_head_a", {16'd0, a_o}, 32'h0011);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("full_a_ready_next", {31'd0, a_ready_o}, 32'd1);
    checkOutput("full_v_next", {31'd0, v_o}, 32'd1);
    checkOutput("full_head_a_next", {16'd0, a_o}, 32'h0033);
    checkOutput("full_head_b_next", {16'd0, b_o}, 32'h0044);

    // Refill to two entries each, then reset mid-stream
    applyStimulus(1, 16'h0066, 1, 16'h0077, 0);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("mid_a_ready_full", {31'd0, a_ready_o}, 32'd0);
    reset_i = 1'b1;
    tick();
    reset_i = 1'b0;
    #1;
    checkOutput("mid_v", {31'd0, v_o}, 32'd0);
    checkOutput("mid_a_o", {16'd0, a_o}, 32'd0);
    checkOutput("mid_b_o", {16'd0, b_o}, 32'd0);
    checkOutput("mid_a_ready", {31'd0, a_ready_o}, 32'd1);
    applyStimulus(1, 16'h1234, 1, 16'h5678, 0);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 1);
    checkOutput("mid_new_v", {31'd0, v_o}, 32'd1);
    checkOutput("mid_new_a", {16'd0, a_o}, 32'h1234);
    checkOutput("mid_new_b", {16'd0, b_o}, 32'h5678);
    tick();
    applyStimulus(0, 16'h0, 0, 16'h0, 0);
    checkOutput("mid_final_v", {31'd0, v_o}, 32'd0);

    @(negedge clk_i);
    #1;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
